// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data requesters
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset
//   i_req/i_addr               fetch request (held until i_ack) and address
//   i_ack/i_rdata              one-cycle fetch completion pulse, registered fetched word
//   d_req/d_we/d_addr/d_wdata  data request (held until d_ack), store flag, address, store data
//   d_ack/d_rdata              one-cycle data completion pulse, registered load data
//   m_req/m_we/m_addr/m_wdata  memory request, held stable for the whole access
//   m_rdata/m_ready            memory read data and completion strobe
//   err                        one-cycle pulse alongside the ack when the access timed out
//   busy                       high whenever a transaction is in flight (ACCESS or RESP)
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // Last wait-state count before the access is abandoned.
    localparam int            CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TW-1:0] CNT_LAST   = CNT_LAST_I[TW-1:0];

    state_t          state_q;
    logic            owner_d_q;   // 1 = data requester owns the current access
    logic            last_d_q;    // 1 = data requester got the most recent grant
    logic [TW-1:0]   cnt_q;
    logic            i_ack_q, d_ack_q, err_q, busy_q, m_req_q, m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q, i_rdata_q, d_rdata_q;

    // Grant decision: data wins only if fetch is idle or fetch won last time.
    logic pick_d_d;
    logic any_req_d;
    always_comb begin
        any_req_d = i_req | d_req;
        pick_d_d  = d_req & (~i_req | ~last_d_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_d_q <= 1'b0;
            last_d_q  <= 1'b1;
            cnt_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        owner_d_q <= pick_d_d;
                        last_d_q  <= pick_d_d;
                        m_addr_q  <= pick_d_d ? d_addr : i_addr;
                        m_we_q    <= pick_d_d & d_we;
                        m_wdata_q <= pick_d_d ? d_wdata : '0;
                        m_req_q   <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    // m_ready takes priority over an expiring timeout.
                    if (m_ready) begin
                        if (!owner_d_q) begin
                            i_rdata_q <= m_rdata;
                        end else if (!m_we_q) begin
                            d_rdata_q <= m_rdata;
                        end
                        m_req_q <= 1'b0;
                        i_ack_q <= ~owner_d_q;
                        d_ack_q <= owner_d_q;
                        state_q <= RESP;
                    end else if (TIMEOUT != 0) begin
                        if (cnt_q == CNT_LAST) begin
                            m_req_q <= 1'b0;
                            i_ack_q <= ~owner_d_q;
                            d_ack_q <= owner_d_q;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RESP: begin
                    // Ack/err were registered on entry; return to IDLE so the
                    // next grant is evaluated one cycle later.
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    m_req_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
